// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, byte width and default baud divisor.
package uart_pkg;
    localparam int NB_BYTE              = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit,
// plus the cycle just before it so callers can register outputs aligned to the bit end.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NB_BAUD_CNT  = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick,
    output logic o_pre_tick
);
    localparam logic [NB_BAUD_CNT-1:0] CNT_LAST = NB_BAUD_CNT'(CLKS_PER_BIT - 1);
    localparam logic [NB_BAUD_CNT-1:0] CNT_PRE  = NB_BAUD_CNT'(CLKS_PER_BIT - 2);

    logic [NB_BAUD_CNT-1:0] cnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign o_tick     = (cnt_reg == CNT_LAST);
    assign o_pre_tick = (cnt_reg == CNT_PRE);
endmodule

// File: rtl/result_uart_tx.sv
// Sends a captured result word MSB byte first as UART frames (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined). All outputs are registered.
module result_uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA      = 16,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NB_BAUD_CNT  = 10
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overrun
);
    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    state_t              state_reg;
    logic [NB_DATA-1:0]  data_reg;
    logic [NB_IDX-1:0]   byte_idx_reg;
    logic [2:0]          bit_idx_reg;
    logic                tx_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                overrun_reg;
    logic                tick;
    logic                pre_tick;
    logic [NB_BYTE-1:0]  cur_byte;

    // Counter is held at zero while idle, so the start bit is a full bit period.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .NB_BAUD_CNT  (NB_BAUD_CNT)
    ) u_baud_tick (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (state_reg == S_IDLE),
        .o_tick     (tick),
        .o_pre_tick (pre_tick)
    );

    // The byte on the wire is always the top byte; the word shifts up after each frame.
    assign cur_byte = data_reg[NB_DATA-1 -: NB_BYTE];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= S_IDLE;
            data_reg     <= '0;
            byte_idx_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (i_valid && busy_reg) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    tx_reg <= 1'b1;
                    if (i_valid) begin
                        data_reg     <= i_data;
                        byte_idx_reg <= NB_IDX'(N_BYTES - 1);
                        state_reg    <= S_START;
                        tx_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        state_reg   <= S_DATA;
                        bit_idx_reg <= 3'd0;
                        tx_reg      <= cur_byte[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= S_PARITY;
                            tx_reg    <= ^cur_byte;
`else
                            state_reg <= S_STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= cur_byte[bit_idx_reg + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        state_reg <= S_STOP;
                        tx_reg    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // o_done is raised one cycle early so it lines up with the final stop cycle.
                    if (pre_tick && byte_idx_reg == '0) begin
                        done_reg <= 1'b1;
                    end
                    if (tick) begin
                        if (byte_idx_reg != '0) begin
                            byte_idx_reg <= byte_idx_reg - 1'b1;
                            data_reg     <= data_reg << NB_BYTE;
                            state_reg    <= S_START;
                            tx_reg       <= 1'b0;
                        end else begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                            tx_reg    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx      = tx_reg;
    assign o_busy    = busy_reg;
    assign o_done    = done_reg;
    assign o_overrun = overrun_reg;
endmodule

// File: tb/tb_result_uart_tx.sv
// Randomized bench for result_uart_tx with a frame-level reference model compared every cycle,
// plus hand-computed line patterns. Honours UART_TX_PARITY_EN.
module tb_result_uart_tx;
    localparam int NB_DATA = 16;
    localparam int CPB     = 4;
    localparam int NBYTES  = NB_DATA / 8;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    localparam int NBITS = NBYTES * FL;
    localparam int TOTAL = NBITS * CPB;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic [NB_DATA-1:0] i_data = '0;
    logic               i_valid = 1'b0;
    logic               o_tx, o_busy, o_done, o_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    result_uart_tx #(
        .NB_DATA      (NB_DATA),
        .CLKS_PER_BIT (CPB),
        .NB_BAUD_CNT  (4)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_tx      (o_tx),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line bits of a whole word in transmission order: start, 8 data LSB first, [parity], stop.
    function automatic logic [NBITS-1:0] frame_bits(input logic [NB_DATA-1:0] w);
        logic [NBITS-1:0] b;
        logic [7:0]       by;
        b = '0;
        for (int k = 0; k < NBYTES; k++) begin
            by = w[(NBYTES-1-k)*8 +: 8];
            b[k*FL] = 1'b0;
            for (int i = 0; i < 8; i++) b[k*FL+1+i] = by[i];
`ifdef UART_TX_PARITY_EN
            b[k*FL+9] = ^by;
`endif
            b[k*FL+FL-1] = 1'b1;
        end
        return b;
    endfunction

    // Reference model: m_pos is the cycle index within the current transfer, -1 when idle.
    int               m_pos = -1;
    logic             m_ovr = 1'b0;
    logic [NBITS-1:0] m_bits = '0;
    logic             m_en = 1'b0;

    always @(posedge i_clk) begin
        if (i_reset) begin
            m_pos <= -1;
            m_ovr <= 1'b0;
            m_en  <= 1'b1;
        end else if (m_pos < 0) begin
            if (i_valid) begin
                m_bits <= frame_bits(i_data);
                m_pos  <= 0;
            end
        end else begin
            if (i_valid) m_ovr <= 1'b1;
            m_pos <= (m_pos + 1 == TOTAL) ? -1 : m_pos + 1;
        end
    end

    always @(negedge i_clk) begin
        if (m_en) begin
            chk("model_tx", {31'd0, o_tx}, {31'd0, (m_pos >= 0) ? m_bits[m_pos / CPB] : 1'b1});
            chk("model_busy", {31'd0, o_busy}, {31'd0, m_pos >= 0});
            chk("model_done", {31'd0, o_done}, {31'd0, m_pos == TOTAL - 1});
            chk("model_overrun", {31'd0, o_overrun}, {31'd0, m_ovr});
        end
    end

    task automatic send(input logic [NB_DATA-1:0] w);
        i_data  = w;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = NB_DATA'($urandom);
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        repeat (n) @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    logic [NBITS-1:0] seq;
    logic [NBITS-1:0] seq_exp;
    int               busy_cnt, done_cnt, done_at;
    logic [NB_DATA-1:0] w1;
    bit               seen;

    initial begin
`ifdef UART_TX_PARITY_EN
        w1      = 16'h0007;
        seq_exp = 22'b11000001110_10000000000;  // MSB = last bit sent
`else
        w1      = 16'hA53C;
        seq_exp = 20'b1001111000_1101001010;    // MSB = last bit sent
`endif
        @(negedge i_clk);
        do_reset(3);
        chk("reset_tx", {31'd0, o_tx}, 32'd1);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_done", {31'd0, o_done}, 32'd0);
        chk("reset_overrun", {31'd0, o_overrun}, 32'd0);

        // Directed word with an overrun attempt at cycle 10.
        send(w1);
        busy_cnt = 0; done_cnt = 0; done_at = 0; seq = '0;
        for (int c = 0; c < TOTAL + 4; c++) begin
            if (c < TOTAL && (c % CPB) == 2) seq[c / CPB] = o_tx;
            busy_cnt += int'(o_busy);
            if (o_done) begin done_cnt++; done_at = c + 1; end
            if (c == 9) begin i_data = 16'h1111; i_valid = 1'b1; end
            else i_valid = 1'b0;
            @(negedge i_clk);
        end
        chk("line_pattern", 32'(seq), 32'(seq_exp));
        chk("busy_cycles", 32'(busy_cnt), 32'(TOTAL));
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_cycle", 32'(done_at), 32'(TOTAL));
        chk("overrun_sticky", {31'd0, o_overrun}, 32'd1);
        do_reset(2);

        // Back-to-back: valid in the cycle after o_done is accepted.
        send(16'hC3C3);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        @(negedge i_clk);
        send(16'h00FF);
        chk("b2b_start_tx", {31'd0, o_tx}, 32'd0);
        chk("b2b_busy", {31'd0, o_busy}, 32'd1);
        repeat (TOTAL + 2) @(negedge i_clk);
        chk("b2b_no_overrun", {31'd0, o_overrun}, 32'd0);

        // Reset in the middle of a frame.
        send(16'h5A5A);
        repeat (19) @(negedge i_clk);
        do_reset(1);
        chk("midreset_tx", {31'd0, o_tx}, 32'd1);
        chk("midreset_busy", {31'd0, o_busy}, 32'd0);
        send(16'h1234);
        repeat (TOTAL + 2) @(negedge i_clk);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            i_reset = ($urandom_range(0, 599) == 0);
            i_valid = ($urandom_range(0, 99) < 4);
            i_data  = NB_DATA'($urandom);
            @(negedge i_clk);
        end
        i_reset = 1'b0;
        i_valid = 1'b0;
        repeat (TOTAL + 2) @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
Serial transmitter at the output end of the CPU result interface. It captures the final result word on its single-cycle valid pulse and sends it over a UART line as 8N1 frames. The word is split into bytes and sent most-significant byte first. It sits between the CPU top-level result/valid outputs and the board TX pin, so a host PC can read program results.

Parameters:
NB_DATA, 16, result word width; must be a multiple of 8.
CLKS_PER_BIT, 868, i_clk cycles per UART bit (100 MHz / 115200); must be ≥ 2.
NB_BAUD_CNT, 10, baud counter width; must satisfy 2^NB_BAUD_CNT > CLKS_PER_BIT.

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-high reset; clock i_clk
i_data  input  NB_DATA  result word; sampled only when i_valid=1 and state is IDLE
i_valid  input  1  single-cycle strobe accompanying i_data
o_tx  output  1  UART serial line; idle high
o_busy  output  1  high from the cycle after capture until the end of the last stop bit
o_done  output  1  1-cycle pulse when the last stop bit completes
o_overrun  output  1  sticky flag: set when i_valid=1 arrives while busy; cleared only by reset

Behaviour:
- Reset values: o_tx=1, o_busy=0, o_done=0, o_overrun=0, state=IDLE, all counters=0.
- Reset mid-frame aborts immediately. o_tx returns high on the next cycle; no partial frame resumes.
- N_BYTES = NB_DATA/8. The byte index counts from N_BYTES-1 down to 0, so the MSB byte goes first.
- States:
  - IDLE: o_tx=1. On i_valid, latch i_data into the shift register, set byte_idx=N_BYTES-1, go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: o_tx=byte[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY (optional): one bit time, then go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. If byte_idx>0, decrement it and go to START back-to-back with no idle gap. If byte_idx=0, pulse o_done and go to IDLE.
- Latency: i_valid is sampled at clock edge k; o_tx=0 and o_busy=1 from edge k+1.
- Frame length per byte: 10 bit times (11 with parity). Total busy time = N_BYTES × 10 × CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - A bit-end tick is asserted when the count equals CLKS_PER_BIT-1.
  - The counter is cleared on capture, so the start bit is exactly CLKS_PER_BIT cycles.
- i_valid while busy: the word is dropped, o_overrun is set, and the current frame is unaffected.
- i_valid in the same cycle as o_done: the block is still busy, so this is an overrun. The word is accepted only from IDLE on the following cycle.
- i_data is not required to be stable after the capture cycle.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit. Frames are 11 bit times.
- Undefined: the PARITY state and its logic are absent, and frames are 8N1 (10 bit times).

Decomposition:
- Shared package/include uart_pkg holds:
  - the state encoding localparams ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3 bits);
  - NB_BYTE=8;
  - the default CLKS_PER_BIT.
- One natural sub-module, uart_baud_tick: a counter with clear input, producing the bit-end tick, parameterised by CLKS_PER_BIT and NB_BAUD_CNT.

Test Plan (CLKS_PER_BIT=4):
- Reset: assert i_reset for 3 cycles -> o_tx=1, o_busy=0, o_done=0, o_overrun=0.
- Send 0xA53C -> line carries byte 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), then 0x3C (0,0,0,1,1,1,1,0,0,1), each bit 4 cycles. o_busy is high for 80 cycles, and o_done pulses once at cycle 80.
- Overrun: i_valid with 0x1111 at cycle 10 of the 0xA53C transfer -> o_overrun=1 and stays 1. The transmitted bytes remain 0xA5, 0x3C.
- Back-to-back: i_valid in the cycle after o_done with 0x00FF -> new start bit begins next cycle. Bytes 0x00, 0xFF are sent, and o_overrun stays 0.
- Reset mid-frame: i_reset at cycle 20 of a transfer -> o_tx=1 and o_busy=0 the next cycle. A subsequent word 0x1234 is sent cleanly.
- UART_TX_PARITY_EN: send 0x0007 -> byte 0x00 has parity bit 0 and byte 0x07 has parity bit 1. Total busy time is 88 cycles.
